vector_loader: RTL and testbench
================================

VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 SHALL have parameter ELEM_W, default 32: element width, signed fixed-point.
REQ-002 SHALL have parameter MAX_LEN, default 6: maximum elements per vector; packed width PW = ELEM_W*MAX_LEN (192).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: length  in  1  0 = 4 elements, 1 = 6 elements; sampled on first accepted beat.
REQ-006 SHALL have ports: operation  in  1  0 add, 1 subtract; sampled with length.
REQ-007 SHALL have ports: s_valid in 1 / s_ready out 1 / s_data in ELEM_W: element input stream, N A-elements then N B-elements.
REQ-008 SHALL have ports: Ain, Bin  out  PW  packed operands, element i at [i*ELEM_W +: ELEM_W].
REQ-009 SHALL have ports: length_out, operation_out  out  1  latched command to the add/sub unit.
REQ-010 SHALL have ports: start out 1 / done in 1 / Cin in PW: level handshake to the add/sub unit.
REQ-011 SHALL have ports: r_valid out 1 / r_ready in 1 / r_data out PW: result output.
REQ-012 SHALL have ports: err  out  1  timeout flag (see Configuration).

Function
REQ-013 SHALL use states IDLE, LOAD_A, LOAD_B, ISSUE, WAIT_DONE, WAIT_CLR, RESULT.
REQ-014 SHALL assert s_ready only in IDLE, LOAD_A, LOAD_B; a beat transfers when s_valid && s_ready.
REQ-015 IDLE: first beat latches length/operation, writes A[0], zeroes all A/B elements at index >= N, enters LOAD_A (or LOAD_B if N-1 == 0, never for N = 4/6).
REQ-016 LOAD_A: beats fill A[1..N-1] in order via an element counter; after A[N-1], counter resets to 0 and state becomes LOAD_B.
REQ-017 LOAD_B: beats fill B[0..N-1]; after B[N-1], state becomes ISSUE; no further beat accepted until return to IDLE.
REQ-018 ISSUE: drive start = 1 next cycle, enter WAIT_DONE; Ain/Bin/length_out/operation_out SHALL stay stable from ISSUE until WAIT_CLR exits.
REQ-019 WAIT_DONE: hold start = 1; on done = 1 capture Cin into r_data, drop start, enter WAIT_CLR.
REQ-020 WAIT_CLR: hold start = 0 until done = 0, then enter RESULT; a new start SHALL never be raised while done = 1.
REQ-021 RESULT: r_valid = 1, r_data stable; on r_ready = 1 clear r_valid and enter IDLE; s_ready may assert the following cycle.
REQ-022 Elements at index >= N in r_data SHALL be passed through from Cin unmodified (add/sub unit zeroes them).
REQ-023 s_valid without s_ready SHALL be ignored; s_data SHALL not be sampled.
REQ-024 done = 1 observed outside WAIT_DONE SHALL be ignored.
REQ-025 Minimum latency, first beat to r_valid: 2N + 2 + T_addsub + 1 cycles, with T_addsub the cycles from start to done.

Reset
REQ-026 On rst = 0 SHALL immediately enter IDLE with start, r_valid, err, s_ready(registered) = 0 and Ain, Bin, r_data, length_out, operation_out, counter = 0.
REQ-027 Reset mid-load or mid-handshake SHALL discard partial vectors; start SHALL fall asynchronously.
REQ-028 After reset release, s_ready SHALL be 1 on the first clock edge in IDLE.

Configuration
REQ-029 Macro VECTOR_LOADER_TIMEOUT_EN defined: 8-bit counter runs in WAIT_DONE; if done is not seen within 255 cycles, SHALL drop start, set err = 1 (sticky until reset or next accepted first beat), discard the result, and go to WAIT_CLR.
REQ-030 Macro undefined: no counter; WAIT_DONE waits indefinitely; err tied 0.

Verification
REQ-031 length=0, op=0, A=1..4 (Q16.16: 0x00010000 steps), B=all 0x00010000, model add/sub -> start after 8 beats, r_data = 2..5, elements 4-5 zero.
REQ-032 length=1, op=1, A=6x 0x00050000, B=6x 0x00020000 -> r_data = 6x 0x00030000; s_ready low from ISSUE to RESULT exit.
REQ-033 s_valid toggling every other cycle, r_ready held 0 for 10 cycles -> correct element order, r_valid/r_data stable while stalled, no beat accepted.
REQ-034 Model holds done = 1 for 5 cycles after start falls -> loader stays in WAIT_CLR, no new start until done = 0.
REQ-035 rst = 0 after 3 B beats, then fresh 8-beat transaction -> start low within reset, result reflects only new data.
REQ-036 With VECTOR_LOADER_TIMEOUT_EN, model never asserts done -> start falls and err = 1 at cycle 255 of WAIT_DONE, no r_valid.

Source files
------------

// File: rtl/vector_loader.sv
// -----------------------------------------------------------------------------
// vector_loader
//
// Collects two operand vectors (A then B) from a single element stream, packs
// them for an external add/sub unit, runs a level start/done handshake with
// that unit and presents the unit's packed result on a valid/ready output.
//
// Vector length is 4 or 6 elements and is chosen, together with the operation,
// on the first accepted beat of a transaction. Elements at index >= N are
// zeroed in both operands.
//
// Optional feature (macro VECTOR_LOADER_TIMEOUT_EN):
//   An 8-bit watchdog runs while waiting for done. If done does not arrive
//   within 255 cycles, start is dropped, err is set (sticky until reset or the
//   next accepted first beat), and the result is discarded. Without the macro
//   the loader waits for done indefinitely and err is tied low.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   length         0 = 4 elements, 1 = 6 elements (sampled on first beat)
//   operation      0 = add, 1 = subtract (sampled on first beat)
//   s_valid/s_ready/s_data   element input stream: N A-elements, N B-elements
//   Ain, Bin       packed operands, element i at [i*ELEM_W +: ELEM_W]
//   length_out, operation_out  latched command to the add/sub unit
//   start/done/Cin level handshake and packed result from the add/sub unit
//   r_valid/r_ready/r_data     packed result output
//   err            watchdog timeout flag
// -----------------------------------------------------------------------------
module vector_loader #(
    parameter int  ELEM_W  = 32,
    parameter int  MAX_LEN = 6,
    localparam int PW      = ELEM_W * MAX_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              length,
    input  logic              operation,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ELEM_W-1:0] s_data,
    output logic [PW-1:0]     Ain,
    output logic [PW-1:0]     Bin,
    output logic              length_out,
    output logic              operation_out,
    output logic              start,
    input  logic              done,
    input  logic [PW-1:0]     Cin,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [PW-1:0]     r_data,
    output logic              err
);

    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Last element index for each supported length.
    localparam logic [CW-1:0] LAST_4 = CW'(3);
    localparam logic [CW-1:0] LAST_6 = CW'(5);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        WAIT_CLR  = 3'd5,
        RESULT    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   a_q, a_d;
    logic [PW-1:0]   b_q, b_d;
    logic            len_q, len_d;
    logic            op_q, op_d;
    logic            start_q, start_d;
    logic            r_valid_q, r_valid_d;
    logic [PW-1:0]   r_data_q, r_data_d;
    logic            s_ready_q, s_ready_d;

    logic            beat_s;
    logic [CW-1:0]   last_s;
    int              n_first_s;

`ifdef VECTOR_LOADER_TIMEOUT_EN
    logic [7:0]      tmo_q, tmo_d;
    logic            discard_q, discard_d;
    logic            err_q, err_d;
`endif

    // Beat qualification uses the registered ready, so a beat offered while
    // busy is never sampled.
    assign beat_s    = s_valid && s_ready_q;
    assign last_s    = len_q ? LAST_6 : LAST_4;
    assign n_first_s = length ? 6 : 4;

    // Next-state and datapath update for the loader FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        len_d     = len_q;
        op_d      = op_q;
        start_d   = start_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
`ifdef VECTOR_LOADER_TIMEOUT_EN
        tmo_d     = tmo_q;
        discard_d = discard_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (beat_s) begin
                    len_d = length;
                    op_d  = operation;
                    // Unused upper elements are cleared in both operands.
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (i >= n_first_s) begin
                            a_d[i*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
                            b_d[i*ELEM_W +: ELEM_W] = {ELEM_W{1'b0}};
                        end else begin
                            a_d[i*ELEM_W +: ELEM_W] = a_q[i*ELEM_W +: ELEM_W];
                            b_d[i*ELEM_W +: ELEM_W] = b_q[i*ELEM_W +: ELEM_W];
                        end
                    end
                    a_d[0 +: ELEM_W] = s_data;
                    cnt_d            = CW'(1);
                    state_d          = LOAD_A;
`ifdef VECTOR_LOADER_TIMEOUT_EN
                    err_d            = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            LOAD_A: begin
                if (beat_s) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (cnt_q == CW'(i)) begin
                            a_d[i*ELEM_W +: ELEM_W] = s_data;
                        end else begin
                            a_d[i*ELEM_W +: ELEM_W] = a_q[i*ELEM_W +: ELEM_W];
                        end
                    end
                    if (cnt_q == last_s) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = LOAD_B;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = LOAD_A;
                end
            end

            LOAD_B: begin
                if (beat_s) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (cnt_q == CW'(i)) begin
                            b_d[i*ELEM_W +: ELEM_W] = s_data;
                        end else begin
                            b_d[i*ELEM_W +: ELEM_W] = b_q[i*ELEM_W +: ELEM_W];
                        end
                    end
                    if (cnt_q == last_s) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ISSUE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = LOAD_B;
                end
            end

            ISSUE: begin
                start_d = 1'b1;
                state_d = WAIT_DONE;
`ifdef VECTOR_LOADER_TIMEOUT_EN
                tmo_d     = 8'd0;
                discard_d = 1'b0;
`endif
            end

            WAIT_DONE: begin
                if (done) begin
                    r_data_d = Cin;
                    start_d  = 1'b0;
                    state_d  = WAIT_CLR;
                end else begin
`ifdef VECTOR_LOADER_TIMEOUT_EN
                    // Count 254 marks the 255th cycle without done.
                    if (tmo_q == 8'd254) begin
                        start_d   = 1'b0;
                        err_d     = 1'b1;
                        discard_d = 1'b1;
                        state_d   = WAIT_CLR;
                    end else begin
                        tmo_d     = tmo_q + 8'd1;
                    end
`else
                    state_d = WAIT_DONE;
`endif
                end
            end

            WAIT_CLR: begin
                // Leaving only once done is low guarantees the next start
                // can never overlap a still-high done.
                if (!done) begin
`ifdef VECTOR_LOADER_TIMEOUT_EN
                    if (discard_q) begin
                        state_d   = IDLE;
                    end else begin
                        r_valid_d = 1'b1;
                        state_d   = RESULT;
                    end
`else
                    r_valid_d = 1'b1;
                    state_d   = RESULT;
`endif
                end else begin
                    state_d = WAIT_CLR;
                end
            end

            RESULT: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d   = RESULT;
                end
            end

            default: begin
                state_d   = IDLE;
                start_d   = 1'b0;
                r_valid_d = 1'b0;
                cnt_d     = {CW{1'b0}};
            end
        endcase

        s_ready_d = (state_d == IDLE) || (state_d == LOAD_A) || (state_d == LOAD_B);
    end

    // State and output registers; reset clears everything and drops start at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            a_q       <= {PW{1'b0}};
            b_q       <= {PW{1'b0}};
            len_q     <= 1'b0;
            op_q      <= 1'b0;
            start_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= {PW{1'b0}};
            s_ready_q <= 1'b0;
`ifdef VECTOR_LOADER_TIMEOUT_EN
            tmo_q     <= 8'd0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            len_q     <= len_d;
            op_q      <= op_d;
            start_q   <= start_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            s_ready_q <= s_ready_d;
`ifdef VECTOR_LOADER_TIMEOUT_EN
            tmo_q     <= tmo_d;
            discard_q <= discard_d;
            err_q     <= err_d;
`endif
        end
    end

    assign s_ready       = s_ready_q;
    assign Ain           = a_q;
    assign Bin           = b_q;
    assign length_out    = len_q;
    assign operation_out = op_q;
    assign start         = start_q;
    assign r_valid       = r_valid_q;
    assign r_data        = r_data_q;
`ifdef VECTOR_LOADER_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_vector_loader.sv
// -----------------------------------------------------------------------------
// tb_vector_loader
//
// Scoreboard bench for vector_loader. The stimulus process pushes the expected
// operands and result of each transaction, computed element-wise from the
// stimulus vectors. An emulated add/sub unit answers start with done/Cin after
// a configurable delay and done hold time. A monitor checks operands when start
// rises, handshake rules every cycle, and pops/compares each presented result.
// -----------------------------------------------------------------------------
module tb_vector_loader;

    localparam int W  = 32;
    localparam int ML = 6;
    localparam int PW = W * ML;

    typedef struct {
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic          len;
        logic          op;
    } ops_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          length = 1'b0;
    logic          operation = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  s_data = '0;
    logic [PW-1:0] Ain, Bin, r_data;
    logic [PW-1:0] Cin = '0;
    logic          length_out, operation_out, start, done, r_valid, err;
    logic          r_ready = 1'b0;
    logic          done_m = 1'b0;
    logic          spur = 1'b0;

    assign done = done_m | spur;

    int checks = 0;
    int failures = 0;
    int n_pushed = 0;
    int n_done = 0;
    int t_cfg = 2;
    int hold_cfg = 0;
    int stall_cfg = 0;
    bit no_done = 1'b0;

    logic [W-1:0]  va[ML];
    logic [W-1:0]  vb[ML];
    logic [PW-1:0] exp_res_q[$];
    ops_t          exp_ops_q[$];

    vector_loader #(.ELEM_W(W), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .length(length), .operation(operation),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .Ain(Ain), .Bin(Bin), .length_out(length_out), .operation_out(operation_out),
        .start(start), .done(done), .Cin(Cin),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // External add/sub unit: element-wise wrap-around add or subtract.
    function automatic logic [PW-1:0] addsub(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic len, input logic op);
        logic [PW-1:0] c = '0;
        for (int i = 0; i < (len ? 6 : 4); i++)
            c[i*W +: W] = op ? (a[i*W +: W] - b[i*W +: W]) : (a[i*W +: W] + b[i*W +: W]);
        return c;
    endfunction

    // Emulated add/sub unit driven from negedges.
    initial begin : addsub_unit
        int wcnt = 0;
        int hcnt = 0;
        bit pstart = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                done_m = 1'b0;
                pstart = 1'b0;
            end else begin
                if (start && !pstart) begin
                    wcnt = t_cfg;
                end else if (start && !done_m && !no_done) begin
                    if (wcnt <= 1) begin
                        Cin    = addsub(Ain, Bin, length_out, operation_out);
                        done_m = 1'b1;
                        hcnt   = hold_cfg;
                    end else begin
                        wcnt--;
                    end
                end else if (done_m && !start) begin
                    if (hcnt == 0) done_m = 1'b0;
                    else hcnt--;
                end
                pstart = start;
            end
        end
    end

    // Monitor: handshake rules, operand checks at start, result scoreboard.
    initial begin : monitor
        bit pstart = 1'b0;
        bit prv = 1'b0;
        logic [PW-1:0] pa = '0, pb = '0, rd0 = '0, e;
        int stall = 0;
        ops_t o;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pstart  = 1'b0;
                prv     = 1'b0;
                r_ready = 1'b0;
            end else begin
                if (start && !pstart) begin
                    chk(done == 1'b0, "start_while_done", PW'(done), PW'(0));
                    chk(exp_ops_q.size() > 0, "start_expected", PW'(start), PW'(0));
                    if (exp_ops_q.size() > 0) begin
                        o = exp_ops_q.pop_front();
                        chk(Ain == o.a, "Ain", Ain, o.a);
                        chk(Bin == o.b, "Bin", Bin, o.b);
                        chk({length_out, operation_out} == {o.len, o.op}, "cmd",
                            PW'({length_out, operation_out}), PW'({o.len, o.op}));
                    end
                end
                if (start && pstart)
                    chk(Ain == pa && Bin == pb, "operand_stable", Ain, pa);
                if (start || r_valid)
                    chk(s_ready == 1'b0, "s_ready_busy", PW'(s_ready), PW'(0));
                if (r_ready) begin
                    r_ready = 1'b0;
                    chk(r_valid == 1'b0, "r_valid_clear", PW'(r_valid), PW'(0));
                end else if (r_valid) begin
                    if (!prv) begin
                        rd0   = r_data;
                        stall = stall_cfg;
                        chk(done == 1'b0, "result_while_done", PW'(done), PW'(0));
                    end else begin
                        chk(r_data == rd0, "r_data_stable", r_data, rd0);
                    end
                    if (stall == 0) begin
                        chk(exp_res_q.size() > 0, "result_expected", r_data, PW'(0));
                        if (exp_res_q.size() > 0) begin
                            e = exp_res_q.pop_front();
                            chk(r_data == e, "r_data", r_data, e);
                        end
                        n_done++;
                        r_ready = 1'b1;
                    end else begin
                        stall--;
                    end
                end
                prv    = r_valid;
                pstart = start;
                pa     = Ain;
                pb     = Bin;
            end
        end
    end

    // One element beat; called at a negedge, returns at a negedge.
    task automatic beat(input logic [W-1:0] d, input bit gap);
        int n = 0;
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            ok = s_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 200);
        chk(ok, "beat_accept", PW'(ok), PW'(1));
        if (gap) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            @(negedge clk);
        end
    endtask

    // Expected operands/result from the stimulus vectors.
    task automatic push_expect(input bit len, input bit op, input bit with_result);
        ops_t o;
        logic [PW-1:0] e = '0;
        o.a = '0; o.b = '0; o.len = len; o.op = op;
        for (int i = 0; i < (len ? 6 : 4); i++) begin
            o.a[i*W +: W] = va[i];
            o.b[i*W +: W] = vb[i];
            e[i*W +: W]   = op ? va[i] - vb[i] : va[i] + vb[i];
        end
        exp_ops_q.push_back(o);
        if (with_result) begin
            exp_res_q.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic send_vectors(input bit len, input bit op, input bit gap, input bit spurious, input int nb);
        int n = len ? 6 : 4;
        length    = len;
        operation = op;
        spur      = spurious;
        for (int i = 0; i < n; i++) begin
            beat(va[i], gap);
            if (i == 0) begin
                length    = 1'($urandom);
                operation = 1'($urandom);
            end
        end
        spur = 1'b0;
        for (int i = 0; i < nb; i++) beat(vb[i], gap);
        s_valid = 1'b0;
    endtask

    task automatic run_txn(input bit len, input bit op, input bit gap, input int t,
                           input int hold, input int stall, input bit spurious);
        int k = 0;
        t_cfg = t; hold_cfg = hold; stall_cfg = stall;
        push_expect(len, op, 1'b1);
        send_vectors(len, op, gap, spurious, len ? 6 : 4);
        while (!start && k < 50) begin @(negedge clk); k++; end
        chk(start == 1'b1, "start_raised", PW'(start), PW'(1));
        // Offer junk beats while busy; none may be taken.
        k = 0;
        while (start && k < 2000) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(negedge clk);
            k++;
        end
        s_valid = 1'b0;
        k = 0;
        while (n_done < n_pushed && k < 3000) begin @(negedge clk); k++; end
        chk(n_done == n_pushed, "result_seen", PW'(n_done), PW'(n_pushed));
    endtask

    task automatic rand_vectors();
        for (int i = 0; i < ML; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stimulus
        int k;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk(s_ready == 1'b0 && start == 1'b0 && r_valid == 1'b0 && err == 1'b0, "reset_ctrl",
            PW'({s_ready, start, r_valid, err}), PW'(0));
        chk(Ain == '0 && Bin == '0, "reset_operands", Ain | Bin, PW'(0));
        chk(r_data == '0 && length_out == 1'b0 && operation_out == 1'b0, "reset_data",
            r_data, PW'(0));
        rst = 1'b1;
        @(negedge clk);
        chk(s_ready == 1'b1, "s_ready_after_reset", PW'(s_ready), PW'(1));

        // 4-element add: 1..4 plus 1.0 in Q16.16.
        for (int i = 0; i < ML; i++) begin
            va[i] = 32'(i + 1) << 16;
            vb[i] = 32'h0001_0000;
        end
        run_txn(1'b0, 1'b0, 1'b0, 3, 0, 0, 1'b0);

        // 6-element subtract: 5.0 - 2.0.
        for (int i = 0; i < ML; i++) begin
            va[i] = 32'h0005_0000;
            vb[i] = 32'h0002_0000;
        end
        run_txn(1'b1, 1'b1, 1'b0, 2, 0, 2, 1'b0);

        // Gapped stream, 10-cycle output stall, stray done during loading.
        rand_vectors();
        run_txn(1'b1, 1'b0, 1'b1, 4, 0, 10, 1'b1);

        // done held 5 cycles after start falls.
        rand_vectors();
        run_txn(1'b0, 1'b1, 1'b0, 1, 5, 0, 1'b0);

        // Reset after 3 B beats: partial vectors discarded.
        rand_vectors();
        send_vectors(1'b0, 1'b0, 1'b0, 1'b0, 3);
        rst = 1'b0;
        #1;
        chk(start == 1'b0 && s_ready == 1'b0, "reset_midload_ctrl", PW'({start, s_ready}), PW'(0));
        chk(Ain == '0 && Bin == '0, "reset_midload_operands", Ain | Bin, PW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset while start is high: start falls without a clock edge.
        rand_vectors();
        t_cfg = 40;
        push_expect(1'b1, 1'b0, 1'b0);
        send_vectors(1'b1, 1'b0, 1'b0, 1'b0, 6);
        k = 0;
        while (!start && k < 50) begin @(negedge clk); k++; end
        chk(start == 1'b1, "start_before_reset", PW'(start), PW'(1));
        #2 rst = 1'b0;
        #1;
        chk(start == 1'b0 && r_valid == 1'b0, "start_async_drop", PW'({start, r_valid}), PW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fresh transaction after resets.
        rand_vectors();
        run_txn(1'b0, 1'b0, 1'b0, 2, 0, 1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            rand_vectors();
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 8)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom));
        end

`ifdef VECTOR_LOADER_TIMEOUT_EN
        // No done ever: watchdog drops start after 255 cycles, no result.
        rand_vectors();
        no_done = 1'b1;
        push_expect(1'b0, 1'b1, 1'b0);
        send_vectors(1'b0, 1'b1, 1'b0, 1'b0, 4);
        k = 0;
        while (!start && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (start && k < 400) begin @(negedge clk); k++; end
        chk(k == 255, "timeout_cycles", PW'(k), PW'(255));
        chk(err == 1'b1, "timeout_err", PW'(err), PW'(1));
        repeat (20) @(negedge clk);
        chk(err == 1'b1, "timeout_err_sticky", PW'(err), PW'(1));
        no_done = 1'b0;
        rand_vectors();
        run_txn(1'b1, 1'b0, 1'b0, 2, 0, 0, 1'b0);
        chk(err == 1'b0, "err_cleared", PW'(err), PW'(0));
`endif

        repeat (5) @(negedge clk);
        chk(exp_res_q.size() == 0 && exp_ops_q.size() == 0, "scoreboard_empty",
            PW'(exp_res_q.size() + exp_ops_q.size()), PW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
